noc_vchannel_mux: RTL and testbench

Packet-atomic virtual-channel multiplexer that sits directly downstream of a compute tile's `link_out_*` ports and feeds the single physical NoC router input. Each of the `CHANNELS` virtual channels is buffered in its own small FIFO. The buffered channels are then serialized onto one output link with round-robin arbitration. Once a channel is granted, it keeps the grant until its packet's `last` flit has been forwarded, so packets are never interleaved.

---
 rtl/noc_vchannel_mux.sv | 160 ++++++++++++++++
 tb/tb_noc_vchannel_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_vchannel_mux.sv
// Packet-atomic virtual-channel mux: per-channel FIFOs, round-robin arbitration,
// grant held from a packet's first pop until its last flit is popped.

module noc_vchannel_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Ready/empty come from the registered count only: a same-cycle pop never frees a slot early.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule

module noc_vchannel_mux #(
    parameter int FLIT_WIDTH   = 34,
    parameter int CHANNELS     = 2,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  link_in_flit,
    input  logic [CHANNELS-1:0]                  link_in_last,
    input  logic [CHANNELS-1:0]                  link_in_valid,
    output logic [CHANNELS-1:0]                  link_in_ready,
    output logic [FLIT_WIDTH-1:0]                link_out_flit,
    output logic                                 link_out_last,
    output logic                                 link_out_valid,
    input  logic                                 link_out_ready,
    output logic [CHANNELS-1:0]                  link_out_channel
);
    localparam int CW = $clog2(CHANNELS);

    typedef struct packed {
        logic                  last;
        logic [FLIT_WIDTH-1:0] flit;
    } flit_t;

    typedef enum logic {IDLE, LOCKED} state_t;

    flit_t [CHANNELS-1:0] fifo_din, fifo_dout;
    logic  [CHANNELS-1:0] push, pop, empty, full;

    state_t        state, state_nxt;
    logic [CW-1:0] rr_ptr, cand;
    logic          cand_ok, loadable, pop_en;
    flit_t         head;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign fifo_din[c]      = '{last: link_in_last[c], flit: link_in_flit[c]};
        assign link_in_ready[c] = !full[c];
        assign push[c]          = link_in_valid[c] & !full[c];

        noc_vchannel_fifo #(.W(FLIT_WIDTH + 1), .DEPTH(BUFFER_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[c]),
            .din   (fifo_din[c]),
            .pop   (pop[c]),
            .dout  (fifo_dout[c]),
            .empty (empty[c]),
            .full  (full[c])
        );
    end

    assign loadable = !link_out_valid | link_out_ready;

    // In LOCKED the owner is always rr_ptr, since rr_ptr is set on the packet's first pop.
    always_comb begin
        int idx;
        idx     = 0;
        cand    = rr_ptr;
        cand_ok = 1'b0;
        if (state == LOCKED) begin
            cand_ok = !empty[rr_ptr];
        end else begin
            // Descending scan so the nearest channel after rr_ptr wins.
            for (int i = CHANNELS; i >= 1; i--) begin
                idx = (int'(rr_ptr) + i) % CHANNELS;
                if (!empty[idx]) begin
                    cand    = CW'(idx);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    assign head = fifo_dout[cand];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop_en && !head.last) state_nxt = LOCKED;
            LOCKED:  if (pop_en &&  head.last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop_en = loadable & cand_ok;
        pop    = pop_en ? (CHANNELS'(1) << cand) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr           <= CW'(CHANNELS - 1);
            link_out_valid   <= 1'b0;
            link_out_flit    <= '0;
            link_out_last    <= 1'b0;
            link_out_channel <= '0;
        end else begin
            if (pop_en && state == IDLE) rr_ptr <= cand;
            if (loadable) begin
                link_out_valid <= pop_en;
                if (pop_en) begin
                    link_out_flit    <= head.flit;
                    link_out_last    <= head.last;
                    link_out_channel <= pop;
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_vchannel_mux.sv
// Directed bench for noc_vchannel_mux: reset, latency, atomicity, round-robin,
// backpressure/full FIFO, mid-packet gap and asynchronous mid-packet reset.

module tb_noc_vchannel_mux;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][33:0] flit_in;
    logic [1:0]       last_in, valid_in, ready_in;
    logic [33:0]      out_flit;
    logic             out_last, out_valid, out_ready;
    logic [1:0]       out_ch;

    int   checks = 0;
    int   errors = 0;
    int   n;
    logic acc;
    logic [33:0] exp_flit [6];
    logic        exp_last [6];

    noc_vchannel_mux #(.FLIT_WIDTH(34), .CHANNELS(2), .BUFFER_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .link_in_flit     (flit_in),
        .link_in_last     (last_in),
        .link_in_valid    (valid_in),
        .link_in_ready    (ready_in),
        .link_out_flit    (out_flit),
        .link_out_last    (out_last),
        .link_out_valid   (out_valid),
        .link_out_ready   (out_ready),
        .link_out_channel (out_ch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; out_ready = 1'b1;
        flit_in = '0; last_in = '0; valid_in = '0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            flit_in[0] = 34'($urandom); flit_in[1] = 34'($urandom);
            last_in = 2'($urandom); valid_in = 2'($urandom);
            tick();
            chk("rst_valid", out_valid, 0);
            chk("rst_ready", ready_in, 2'b11);
        end
        chk("rst_flit", out_flit, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ch", out_ch, 0);
        flit_in = '0; last_in = '0; valid_in = '0;
        tick();
        rst = 1'b1;

        // first flit on ch1 alone: 2-cycle latency
        flit_in[1] = 34'h1_0001; last_in = 2'b10; valid_in = 2'b10;
        tick();
        valid_in = '0; last_in = '0;
        chk("lat_early", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("lat_ch", out_ch, 2'b10);
        chk("lat_flit", out_flit, 34'h1_0001);
        chk("lat_last", out_last, 1);
        tick();
        chk("lat_idle", out_valid, 0);

        // packet atomicity: A0..A2 on ch0, B0..B2 on ch1, same start cycle
        for (int k = 0; k < 3; k++) begin
            exp_flit[k] = 34'(32'hA00 + k); exp_last[k] = (k == 2);
            exp_flit[k+3] = 34'(32'hB00 + k); exp_last[k+3] = (k == 2);
        end
        for (int i = 0; i <= 6; i++) begin
            if (i < 3) begin
                flit_in[0] = exp_flit[i]; flit_in[1] = exp_flit[i+3];
                last_in = (i == 2) ? 2'b11 : 2'b00; valid_in = 2'b11;
            end else begin
                valid_in = '0; last_in = '0;
            end
            tick();
            if (i >= 1) begin
                chk("atom_valid", out_valid, 1);
                chk("atom_flit", out_flit, exp_flit[i-1]);
                chk("atom_last", out_last, exp_last[i-1]);
            end
        end
        tick();
        chk("atom_idle", out_valid, 0);

        // round-robin with continuous single-flit packets on both channels
        flit_in[0] = 34'hC0; flit_in[1] = 34'hC1; last_in = 2'b11; valid_in = 2'b11;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_ch", out_ch, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_flit", out_flit, (k % 2 == 0) ? 34'hC0 : 34'hC1);
        end
        valid_in = '0; last_in = '0;
        repeat (12) tick();
        chk("rr_drain", out_valid, 0);

        // mid-packet gap on ch0 while ch1 fills with ready packets
        flit_in[0] = 34'hA0; last_in = 2'b00; valid_in = 2'b01;
        tick();
        flit_in[1] = 34'hD1; last_in = 2'b10; valid_in = 2'b10;
        tick();
        chk("gap_a0_flit", out_flit, 34'hA0);
        chk("gap_a0_ch", out_ch, 2'b01);
        chk("gap_a0_last", out_last, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                flit_in[0] = 34'hA1; last_in = 2'b11; valid_in = 2'b11;
            end
            tick();
            chk("gap_hold", out_valid, 0);
        end
        chk("gap_ch1_full", ready_in[1], 0);
        valid_in = '0; last_in = '0;
        tick();
        chk("gap_a1_flit", out_flit, 34'hA1);
        chk("gap_a1_last", out_last, 1);
        chk("gap_a1_ch", out_ch, 2'b01);
        tick();
        chk("gap_ch1_ch", out_ch, 2'b10);
        chk("gap_ch1_flit", out_flit, 34'hD1);
        repeat (5) tick();
        chk("gap_idle", out_valid, 0);

        // backpressure: 6 flits offered on ch0 with the router stalled
        out_ready = 1'b0; n = 0; last_in = '0;
        for (int k = 0; k < 6; k++) begin
            valid_in = 2'b01; flit_in[0] = 34'(32'hE0 + n);
            acc = ready_in[0];
            tick();
            if (acc) n++;
            if (k == 2) chk("bp_stable", out_flit, 34'hE0);
        end
        chk("bp_accepted", n, 5);
        chk("bp_full", ready_in[0], 0);
        chk("bp_head", out_flit, 34'hE0);
        chk("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (n < 6) begin
                valid_in = 2'b01; flit_in[0] = 34'(32'hE0 + n);
            end else begin
                valid_in = '0;
            end
            acc = valid_in[0] & ready_in[0];
            tick();
            if (acc) n++;
            chk("bp_drain_flit", out_flit, 34'(32'hE0 + k));
            chk("bp_drain_valid", out_valid, 1);
        end
        chk("bp_total", n, 6);
        tick();
        chk("bp_idle", out_valid, 0);

        // asynchronous reset after the first flit of a 3-flit packet
        flit_in[0] = 34'hF0; last_in = '0; valid_in = 2'b01;
        tick();
        flit_in[0] = 34'hF1;
        tick();
        chk("rm_f0", out_flit, 34'hF0);
        valid_in = '0;
        #2 rst = 1'b0;
        #1;
        chk("rm_valid", out_valid, 0);
        chk("rm_flit", out_flit, 0);
        chk("rm_ch", out_ch, 0);
        chk("rm_ready", ready_in, 2'b11);
        tick();
        tick();
        rst = 1'b1;
        flit_in[1] = 34'h60; last_in = 2'b00; valid_in = 2'b10;
        tick();
        flit_in[1] = 34'h61; last_in = 2'b10;
        tick();
        valid_in = '0; last_in = '0;
        chk("rm_g0_flit", out_flit, 34'h60);
        chk("rm_g0_ch", out_ch, 2'b10);
        chk("rm_g0_last", out_last, 0);
        tick();
        chk("rm_g1_flit", out_flit, 34'h61);
        chk("rm_g1_last", out_last, 1);
        tick();
        chk("rm_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
